// File: rtl/mem_if_pkg.sv
// Shared constants and FSM state type for the data memory responder.
package mem_if_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned DEFAULT_ADDR_W = 10;
  localparam int unsigned DEFAULT_DEPTH  = 1024;
  localparam int unsigned CNT_W          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Index width needed to address DEPTH words (at least one bit).
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, registered read port with a clear so the
// read register doubles as the response data output.
module mem_array
  import mem_if_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned IDX_W = idx_width(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              rd_clr,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rd_clr)     rdata <= '0;
    else if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with fixed access latency.
// Requests are latched on accept and committed to memory when RESP is entered.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter int unsigned DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int unsigned      IDX_W    = idx_width(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;

  logic                commit_c;
  logic                consume_c;
  logic                in_range_c;
  logic                cmd_we_c;
  logic [ADDR_W-1:0]   cmd_addr_c;
  logic [DATA_W-1:0]   cmd_wdata_c;

  // With LATENCY 1 the commit happens on the accept edge, straight from req_*.
  always_comb begin
    cmd_we_c    = lat_we;
    cmd_addr_c  = lat_addr;
    cmd_wdata_c = lat_wdata;
    commit_c    = 1'b0;
    if (state == IDLE) begin
      cmd_we_c    = req_we;
      cmd_addr_c  = req_addr;
      cmd_wdata_c = req_wdata;
      commit_c    = req_valid && (LATENCY == 1);
    end else if (state == WAIT) begin
      commit_c = (cnt == CNT_ONE);
    end
    commit_c   = commit_c && !reset;
    in_range_c = 64'(cmd_addr_c) < 64'(DEPTH);
    consume_c  = (state == RESP) && resp_ready;
  end

  mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk    (clk),
    .wr_en  (commit_c && cmd_we_c && in_range_c),
    .rd_en  (commit_c && !cmd_we_c && in_range_c),
    .rd_clr (reset || consume_c),
    .addr   (cmd_addr_c[IDX_W-1:0]),
    .wdata  (cmd_wdata_c),
    .rdata  (resp_rdata)
  );

  // Control FSM; WAIT leaves on the edge where the counter reaches zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (LATENCY == 1) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= !in_range_c;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= !in_range_c;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (LATENCY 2/DEPTH 512,
// LATENCY 3, LATENCY 1) driven from a vector table plus corner sequences.
module tb_data_mem_responder;

  logic        clk;
  logic        reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [2:0]  req_we;
  logic [9:0]  req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [2:0]  resp_valid;
  logic [2:0]  resp_ready;
  logic [31:0] resp_rdata [3];
  logic [2:0]  resp_err;
  logic [2:0]  busy;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    int          dut;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    int          hold;
    logic        scramble;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  data_mem_responder #(.ADDR_W(10), .DEPTH(512), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .busy(busy[0]));

  data_mem_responder #(.ADDR_W(10), .DEPTH(1024), .LATENCY(3)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .busy(busy[1]));

  data_mem_responder #(.ADDR_W(10), .DEPTH(1024), .LATENCY(1)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
    .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]), .resp_rdata(resp_rdata[2]),
    .resp_err(resp_err[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 3;
      default: return 1;
    endcase
  endfunction

  function automatic vec_t mk(input int d, input logic we, input int addr,
                              input logic [31:0] wd, input int hold, input logic scr,
                              input logic [31:0] rd, input logic err);
    vec_t v;
    v.dut = d; v.we = we; v.addr = 10'(addr); v.wdata = wd;
    v.hold = hold; v.scramble = scr; v.rdata = rd; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input int d, input string tag);
    chk({tag, "_req_ready"},  32'(req_ready[d]),  32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid[d]), 32'd0);
    chk({tag, "_resp_err"},   32'(resp_err[d]),   32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata[d],      32'd0);
    chk({tag, "_busy"},       32'(busy[d]),       32'd0);
  endtask

  // One request/response: latency, hold stability, scoreboard compare, idle return.
  task automatic do_vec(input vec_t v);
    int   d;
    int   n;
    exp_t e;
    d = v.dut;
    n = 0;
    while (!req_ready[d] && n < 50) begin @(posedge clk); #1; n++; end
    chk("ready_before_req", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_we[d]    = v.we;
    req_addr[d]  = v.addr;
    req_wdata[d] = v.wdata;
    sbq.push_back('{d, v.rdata, v.err});
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    if (v.scramble) begin
      req_we[d]    = ~v.we;
      req_addr[d]  = v.addr + 10'd1;
      req_wdata[d] = ~v.wdata;
    end
    chk("busy_after_accept", 32'(busy[d]), 32'd1);
    chk("ready_low_after_accept", 32'(req_ready[d]), 32'd0);
    n = 1;
    while (!resp_valid[d] && n < 50) begin @(posedge clk); #1; n++; end
    chk("latency", 32'(n), 32'(lat_of(d)));
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid[d]), 32'd1);
      chk("hold_rdata", resp_rdata[d], v.rdata);
      chk("hold_ready", 32'(req_ready[d]), 32'd0);
    end
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk("sb_dut", 32'(d), 32'(e.dut));
      chk("resp_rdata", resp_rdata[d], e.rdata);
      chk("resp_err", 32'(resp_err[d]), 32'(e.err));
    end
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    chk_idle(d, "after_consume");
  endtask

  initial begin
    int   cyc;
    int   issued;
    int   done;
    int   last_acc;
    int   saw;
    logic acc;
    logic rsp;
    exp_t e;

    reset      = 1'b1;
    req_valid  = '0;
    req_we     = '0;
    resp_ready = '0;
    for (int d = 0; d < 3; d++) begin
      req_addr[d]  = '0;
      req_wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk_idle(d, "reset");
    reset = 1'b0;

    vecs.push_back(mk(0, 1'b1,    5, 32'hDEADBEEF, 0, 1'b0, 32'h0,        1'b0));
    vecs.push_back(mk(0, 1'b0,    5, 32'h0,        0, 1'b0, 32'hDEADBEEF, 1'b0));
    vecs.push_back(mk(0, 1'b1,   88, 32'hA5A50088, 1, 1'b0, 32'h0,        1'b0));
    vecs.push_back(mk(0, 1'b1,  600, 32'h11111111, 0, 1'b0, 32'h0,        1'b1));
    vecs.push_back(mk(0, 1'b0,  600, 32'h0,        2, 1'b0, 32'h0,        1'b1));
    vecs.push_back(mk(0, 1'b0,   88, 32'h0,        0, 1'b0, 32'hA5A50088, 1'b0));
    vecs.push_back(mk(0, 1'b1,  511, 32'hCAFEF00D, 0, 1'b0, 32'h0,        1'b0));
    vecs.push_back(mk(0, 1'b0,  511, 32'h0,        0, 1'b0, 32'hCAFEF00D, 1'b0));
    vecs.push_back(mk(0, 1'b0,  512, 32'h0,        0, 1'b0, 32'h0,        1'b1));
    vecs.push_back(mk(0, 1'b1,   10, 32'h00001010, 0, 1'b0, 32'h0,        1'b0));
    vecs.push_back(mk(0, 1'b1,    9, 32'h00000099, 0, 1'b1, 32'h0,        1'b0));
    vecs.push_back(mk(0, 1'b0,    9, 32'h0,        0, 1'b0, 32'h00000099, 1'b0));
    vecs.push_back(mk(0, 1'b0,   10, 32'h0,        0, 1'b0, 32'h00001010, 1'b0));
    vecs.push_back(mk(1, 1'b1, 1023, 32'h0BADF00D, 4, 1'b0, 32'h0,        1'b0));
    vecs.push_back(mk(1, 1'b0, 1023, 32'h0,        4, 1'b0, 32'h0BADF00D, 1'b0));
    vecs.push_back(mk(1, 1'b1,    7, 32'h00000055, 0, 1'b0, 32'h0,        1'b0));
    vecs.push_back(mk(1, 1'b0,    7, 32'h0,        0, 1'b1, 32'h00000055, 1'b0));
    vecs.push_back(mk(2, 1'b1,    3, 32'h00000033, 0, 1'b1, 32'h0,        1'b0));
    vecs.push_back(mk(2, 1'b0,    3, 32'h0,        2, 1'b0, 32'h00000033, 1'b0));

    foreach (vecs[i]) do_vec(vecs[i]);

    // Back-to-back on the LATENCY 1 unit with resp_ready tied high.
    resp_ready[2] = 1'b1;
    issued   = 0;
    done     = 0;
    last_acc = -1;
    req_valid[2] = 1'b1;
    req_we[2]    = 1'b1;
    req_addr[2]  = 10'd20;
    req_wdata[2] = 32'h2000;
    for (cyc = 0; cyc < 60 && done < 8; cyc++) begin
      acc = req_valid[2] && req_ready[2];
      rsp = resp_valid[2] && resp_ready[2];
      if (rsp) begin
        chk("b2b_resp_delay", 32'(cyc - last_acc), 32'd1);
        if (sbq.size() == 0) begin
          chk("b2b_scoreboard_empty", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("b2b_rdata", resp_rdata[2], e.rdata);
          chk("b2b_err", 32'(resp_err[2]), 32'(e.err));
        end
        done++;
      end
      if (acc) begin
        sbq.push_back('{2, (issued < 4) ? 32'h0 : 32'h2000 + 32'(issued - 4), 1'b0});
        if (last_acc >= 0) chk("b2b_spacing", 32'(cyc - last_acc), 32'd2);
        last_acc = cyc;
        issued++;
      end
      @(posedge clk); #1;
      if (acc) begin
        if (issued < 8) begin
          req_we[2]    = (issued < 4);
          req_addr[2]  = 10'(20 + (issued % 4));
          req_wdata[2] = 32'h2000 + 32'(issued);
        end else begin
          req_valid[2] = 1'b0;
        end
      end
    end
    chk("b2b_done", 32'(done), 32'd8);
    resp_ready[2] = 1'b0;
    req_valid[2]  = 1'b0;

    // Reset on the would-be commit edge of a LATENCY 3 store.
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_addr[1]  = 10'd7;
    req_wdata[1] = 32'h00000012;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("rst_wait_busy", 32'(busy[1]), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_idle(1, "rst_in_wait");
    saw = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp_valid[1]) saw++;
    end
    chk("rst_no_resp", 32'(saw), 32'd0);
    do_vec(mk(1, 1'b0, 7, 32'h0, 0, 1'b0, 32'h00000055, 1'b0));
    do_vec(mk(0, 1'b0, 5, 32'h0, 0, 1'b0, 32'hDEADBEEF, 1'b0));
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
